// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller: one-cycle multiply, WIDTH-cycle restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and overflow skip the iteration loop.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MUL   | one cycle to form the product from latched operands
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result valid, held until out_ready
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_MULH   = 4'b1011;
    localparam logic [3:0] OP_MULHSU = 4'b1100;
    localparam logic [3:0] OP_MULHU  = 4'b1101;
    localparam logic [3:0] OP_DIV    = 4'b1110;
    localparam logic [3:0] OP_REM    = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] op1_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;

    logic             accept;
    logic             is_div_in;
    logic             dz_in;
    logic             ovf_in;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   div_res;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mul_res;

    // Divide-by-zero and overflow answers; shared by the early-out and full-length paths.
    function automatic logic [WIDTH-1:0] special_res(input logic is_div,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic dz);
        if (dz) return is_div ? '1 : a;
        else    return is_div ? a : '0;
    endfunction

    assign in_ready  = (state_q == IDLE) && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    assign is_div_in = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign dz_in     = (op2 == '0);
    assign ovf_in    = (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1);
    assign op1_mag   = op1[WIDTH-1] ? -op1 : op1;
    assign op2_mag   = op2[WIDTH-1] ? -op2 : op2;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
        rem_d   = shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        div_res = '0;
        if (dz_q || ovf_q)
            div_res = special_res(op_q == OP_DIV, op1_q, dz_q);
        else if (op_q == OP_DIV)
            div_res = q_neg_q ? -quo_d : quo_d;
        else
            div_res = r_neg_q ? -rem_d : rem_d;
    end

    // Sign-extending both operands to 2*WIDTH lets one unsigned multiply serve every variant.
    assign a_ext = {{WIDTH{op1_q[WIDTH-1] & ((op_q == OP_MULH) || (op_q == OP_MULHSU))}}, op1_q};
    assign b_ext = {{WIDTH{dsr_q[WIDTH-1] & (op_q == OP_MULH)}}, dsr_q};
    assign prod  = a_ext * b_ext;

    always_comb begin
        case (op_q)
            OP_MUL:                       mul_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mul_res = prod[2*WIDTH-1:WIDTH];
            default:                      mul_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            op1_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= alu_op;
                        op1_q   <= op1;
                        cnt_q   <= CNT_LAST;
                        rem_q   <= '0;
                        q_neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
                        r_neg_q <= op1[WIDTH-1];
                        dz_q    <= dz_in;
                        ovf_q   <= ovf_in;
                        if (is_div_in) begin
                            quo_q <= op1_mag;
                            dsr_q <= op2_mag;
`ifdef MULDIV_EARLY_OUT_EN
                            if (dz_in || ovf_in) begin
                                result_q    <= special_res(alu_op == OP_DIV, op1, dz_in);
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                state_q <= DIV;
                            end
`else
                            state_q <= DIV;
`endif
                        end else begin
                            quo_q   <= '0;
                            dsr_q   <= op2;
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    result_q    <= mul_res;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        result_q    <= div_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with an expected-result queue and a small arithmetic model.
// Honours MULDIV_EARLY_OUT_EN when computing expected latency of special divide cases.
module tb_muldiv_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    logic [W-1:0] last_result;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op1(op1), .op2(op2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            4'b1010: begin p = sa * sb; return p[31:0];  end
            4'b1011: begin p = sa * sb; return p[63:32]; end
            4'b1100: begin p = sa * ub; return p[63:32]; end
            4'b1101: begin p = ua * ub; return p[63:32]; end
            4'b1110: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            4'b1111: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                return $signed(a) % $signed(b);
            end
            default: return '0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        if (op == 4'b1110 || op == 4'b1111) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
            return W + 1;
        end
        return 2;
    endfunction

    // Issue one request, then wait (bounded) for out_valid and compare against the queue.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e, input string tag);
        int n;
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; op1 = a; op2 = b;
        #1 check({tag, " in_ready"}, W'(in_ready), W'(1));
        @(posedge clk);
        exp_q.push_back(e);
        lat_q.push_back(exp_lat(op, a, b));
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, W'(n), W'(lat_q.pop_front()));
        last_result = exp_q.pop_front();
        check({tag, " result"}, result, last_result);
        if (out_ready) begin
            @(negedge clk);
            check({tag, " out_valid_after"}, W'(out_valid), W'(0));
            check({tag, " in_ready_after"}, W'(in_ready), W'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] held;
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;
        int           n_ov;

        rst = 1'b1; in_valid = 1'b0; alu_op = '0; op1 = '0; op2 = '0;
        flush = 1'b0; out_ready = 1'b1; last_result = '0;
        repeat (3) @(negedge clk);
        check("rst in_ready", W'(in_ready), W'(0));
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst result", result, '0);
        check("rst busy", W'(busy), W'(0));
        rst = 1'b0;
        #1 check("post-rst in_ready", W'(in_ready), W'(1));

        run_op(4'b1010, -32'sd6, 32'd7, 32'hFFFF_FFD6, "mul");
        run_op(4'b1011, -32'sd6, 32'd7, 32'hFFFF_FFFF, "mulh");
        run_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
        run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(4'b0011, 32'd5, 32'd7, 32'h0000_0000, "undef_op");
        run_op(4'b1110, -32'sd20, 32'd6, 32'hFFFF_FFFD, "div");
        run_op(4'b1111, -32'sd20, 32'd6, 32'hFFFF_FFFE, "rem");
        run_op(4'b1110, 32'd20, 32'd0, 32'hFFFF_FFFF, "div_zero");
        run_op(4'b1111, 32'd20, 32'd0, 32'd20, "rem_zero");
        run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        for (int i = 0; i < 8; i++) begin
            rop = 4'(10 + $urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 2 == 1) rb = rb >> $urandom_range(0, 28);
            if (i == 5) rb = '0;
            run_op(rop, ra, rb, model(rop, ra, rb), "rand");
        end

        // Backpressure: result must hold and no request may be taken while DONE.
        out_ready = 1'b0;
        run_op(4'b1010, 32'd1234, 32'd5678, 32'd7006652, "bp_mul");
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp result", result, held);
            check("bp in_ready", W'(in_ready), W'(0));
            check("bp out_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", W'(out_valid), W'(0));
        check("bp release in_ready", W'(in_ready), W'(1));
        check("bp release busy", W'(busy), W'(0));

        // Flush at accept+10 of a divide.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b1110; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("flush busy_before", W'(busy), W'(1));
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", W'(busy), W'(0));
        check("flush out_valid", W'(out_valid), W'(0));
        #1 check("flush in_ready_after", W'(in_ready), W'(1));
        n_ov = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n_ov++;
        end
        check("flush no out_valid", W'(n_ov), W'(0));
        check("flush result kept", result, last_result);

        // Reset at accept+5 of a divide, then a fresh multiply.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b1110; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("midrst in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        check("midrst out_valid", W'(out_valid), W'(0));
        check("midrst result", result, '0);
        check("midrst busy", W'(busy), W'(0));
        rst = 1'b0;
        #1 check("midrst in_ready_after", W'(in_ready), W'(1));
        n_ov = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n_ov++;
        end
        check("midrst no out_valid", W'(n_ov), W'(0));
        run_op(4'b1010, -32'sd6, 32'd7, 32'hFFFF_FFD6, "mul_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the controller can accept a request.
REQ-006 The module SHALL have port alu_op, input, 4 bits: the operation code (1010 MUL, 1011 MULH, 1100 MULHSU, 1101 MULHU, 1110 DIV, 1111 REM).
REQ-007 The module SHALL have ports op1 and op2, input, WIDTH bits each: the operands.
REQ-008 The module SHALL have port flush, input, 1 bit: kills any in-flight operation.
REQ-009 The module SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The module SHALL have port result, output, WIDTH bits: the registered result.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE; drives pipeline stall.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 in_ready SHALL equal (state==IDLE && !flush && !rst); a request is accepted on an edge where in_valid && in_ready, with op1, op2 and alu_op latched at that edge.
REQ-015 Accepting an op in 1010..1101 SHALL go IDLE->MUL; MUL lasts one cycle, then ->DONE; out_valid rises 2 cycles after the accept edge.
REQ-016 MUL/MULH/MULHSU/MULHU SHALL return, respectively, the low WIDTH bits of the product, and the high WIDTH bits of the signed x signed, signed x unsigned (op1 signed) and unsigned x unsigned 2*WIDTH-bit products.
REQ-017 Accepting 1110/1111 SHALL go IDLE->DIV: restoring division on operand magnitudes, one quotient bit per cycle, exactly WIDTH cycles counted by a $clog2(WIDTH)-bit counter, then ->DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-018 DIV SHALL round the quotient toward zero; REM SHALL take the sign of the dividend.
REQ-019 Divide by zero SHALL give DIV = all-ones and REM = op1.
REQ-020 Overflow (op1 = most-negative value, op2 = all-ones) SHALL give DIV = op1 and REM = 0.
REQ-021 Ops 0000..1001 SHALL be accepted, follow the MUL path and latency, and return 0.
REQ-022 In DONE, out_valid SHALL be 1 and result SHALL be held stable until out_ready; on the out_valid && out_ready edge the FSM SHALL go ->IDLE.
REQ-023 No new request SHALL be accepted in the same cycle as result handshake (in_ready is low in DONE).
REQ-024 flush=1 in any cycle SHALL force ->IDLE on the next edge, clear out_valid and discard the result; flush SHALL take priority over in_valid, out_ready and iteration completion.
REQ-025 result SHALL change only on entry to DONE or on reset.

Reset
REQ-026 While rst=1 at an edge: state SHALL become IDLE, out_valid 0, result 0, busy 0, counter 0; rst SHALL take priority over flush and any handshake.
REQ-027 Reset mid-DIV or mid-DONE SHALL abandon the operation without producing out_valid.
REQ-028 in_ready SHALL be 0 during rst and 1 in the first cycle after rst deasserts.

Configuration
REQ-029 When MULDIV_EARLY_OUT_EN is defined, divide-by-zero and overflow cases SHALL go IDLE->DONE directly, with out_valid 1 cycle after the accept edge.
REQ-030 When MULDIV_EARLY_OUT_EN is undefined, those cases SHALL take the full WIDTH-cycle DIV path; the results of REQ-019/020 SHALL be identical in both builds.

Verification
REQ-031 MUL: op1=-6, op2=7, alu_op=1010, out_ready=1 -> out_valid at accept+2, result=0xFFFFFFD6; MULH with the same operands -> 0xFFFFFFFF.
REQ-032 DIV: op1=-20, op2=6, alu_op=1110 -> out_valid at accept+33, result=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFE (-2).
REQ-033 Div by zero: op1=20, op2=0, DIV -> 0xFFFFFFFF; REM -> 20; latency is accept+1 with MULDIV_EARLY_OUT_EN, accept+33 without.
REQ-034 Overflow: op1=0x80000000, op2=0xFFFFFFFF, DIV -> 0x80000000; REM -> 0.
REQ-035 Backpressure: out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 Flush/reset: flush asserted at accept+10 of DIV -> IDLE next cycle and no out_valid; rst asserted at accept+5 -> all outputs 0 next cycle and a fresh MUL completes correctly.
